// File: rtl/mips_cpu_muldiv_ctrl.sv
// HI/LO sequencer: drives the external 32x32 multiplier, runs a restoring divider and owns the hi/lo registers.
// Latency: MTHI/MTLO 1 edge; mul 3 edges to done; div 34 edges; divide-by-zero 2 edges (accept edge counted).
// Backpressure: op_ready is high only in IDLE, so decode must hold op_valid until it is accepted. Optional: MULDIV_MADD_EN.
module mips_cpu_muldiv_ctrl #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sign,
    input  logic [63:0] mul_out,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;
    localparam int CW = $clog2(DIV_ITER + 1);

    typedef enum logic [2:0] {IDLE, MUL_ISSUE, MUL_WB, DIV_RUN, DIV_FIX} state_t;

    state_t        state, state_n;
    logic [31:0]   a_q, b_q, rem_q, quo_q, dvsr_q;
    logic [2:0]    code_q;
    logic [CW-1:0] cnt_q;
    logic          accept, signed_in, signed_q;
    logic [31:0]   mag_a, mag_b, rem_n, q_fix, r_fix;
    logic [32:0]   shifted, diff;
    logic [63:0]   wb_val;

    assign op_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = op_valid & op_ready;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_sign  = (code_q == OP_MULT) || (code_q == OP_MADD);
    assign signed_in = (op_code == OP_DIV);
    assign signed_q  = (code_q == OP_DIV);
    // Signed divide works on magnitudes; sign fix-up happens in DIV_FIX.
    assign mag_a     = (signed_in && op_a[31]) ? -op_a : op_a;
    assign mag_b     = (signed_in && op_b[31]) ? -op_b : op_b;

    // One restoring step; 33-bit partial remainder so unsigned divisors near 2^32 cannot overflow.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvsr_q};
        rem_n   = diff[32] ? shifted[31:0] : diff[31:0];
        q_fix   = (signed_q && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
        r_fix   = (signed_q && a_q[31]) ? -rem_q : rem_q;
`ifdef MULDIV_MADD_EN
        wb_val  = code_q[2] ? ({hi, lo} + mul_out) : mul_out;
`else
        wb_val  = mul_out;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: state_n = MUL_ISSUE;
                        OP_DIV, OP_DIVU:   state_n = (op_b == 32'd0) ? DIV_FIX : DIV_RUN;
`ifdef MULDIV_MADD_EN
                        OP_MADD, OP_MADDU: state_n = MUL_ISSUE;
`endif
                        default:           state_n = IDLE;
                    endcase
                end
            end
            MUL_ISSUE: state_n = MUL_WB;
            MUL_WB:    state_n = IDLE;
            DIV_RUN:   state_n = (cnt_q == CW'(DIV_ITER - 1)) ? DIV_FIX : DIV_RUN;
            DIV_FIX:   state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Operand latches, divider datapath, HI/LO writeback and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            code_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == MUL_WB) || (state == DIV_FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        code_q <= op_code;
                        rem_q  <= '0;
                        quo_q  <= mag_a;
                        dvsr_q <= mag_b;
                        cnt_q  <= '0;
                        if (op_code == OP_MTHI) hi <= op_a;
                        if (op_code == OP_MTLO) lo <= op_a;
                    end
                end
                DIV_RUN: begin
                    rem_q <= rem_n;
                    quo_q <= {quo_q[30:0], ~diff[32]};
                    cnt_q <= cnt_q + 1'b1;
                end
                MUL_WB: begin
                    {hi, lo} <= wb_val;
                end
                DIV_FIX: begin
                    if (b_q == 32'd0) begin
                        lo <= 32'hFFFF_FFFF;
                        hi <= a_q;
                    end else begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
module tb_mips_cpu_muldiv_ctrl;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADDU = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a, op_b;
    logic        op_ready;
    logic [31:0] mul_a, mul_b;
    logic        mul_sign;
    logic [63:0] mul_out = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   rdy_low = 0;

    mips_cpu_muldiv_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .mul_a(mul_a), .mul_b(mul_b),
        .mul_sign(mul_sign), .mul_out(mul_out), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Registered 32x32 multiplier: sign-extend when signed, keep the low 64 bits.
    always @(posedge clk)
        mul_out <= {{32{mul_sign & mul_a[31]}}, mul_a} * {{32{mul_sign & mul_b[31]}}, mul_b};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (!op_ready) rdy_low++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
    end

    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input int lat, output int acc, output int waited);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = code;
        op_a     = a;
        op_b     = b;
        while (!op_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!op_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        acc = cyc;
        waited = w;
        if (push) begin
            e.hi = eh; e.lo = el; e.acc = acc; e.lat = lat;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sb_q.size() != 0) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input int ebusy);
        int acc, w;
        busy_cnt = 0;
        rdy_low  = 0;
        issue(code, a, b, 1'b1, eh, el, lat, acc, w);
        wait_idle();
        chk({tag, "_busy"}, 64'(busy_cnt), 64'(ebusy));
        chk({tag, "_rdy_low"}, 64'(rdy_low), 64'(ebusy));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, w;
        reset = 1'b1; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;

        run("mult",   OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 3, 2);
        run("multu",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3, 2);
        run("mult_neg", OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 3, 2);
        run("div",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33);
        run("divu",   OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34, 33);
        run("div_nb", OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34, 33);
        run("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        32'd1,         34, 33);
        run("divu_3", OP_DIVU,  32'hFFFF_FFFF, 32'd3,         32'd0,         32'h5555_5555, 34, 33);
        run("divz",   OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 2, 1);
        run("div_ovf", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34, 33);

        // Divide still running while decode already holds the next request.
        issue(OP_DIV, 32'd20, 32'd3, 1'b1, 32'd2, 32'd6, 34, acc1, w);
        issue(OP_MTLO, 32'h0000_ABCD, 32'd0, 1'b0, 32'd0, 32'd0, 0, acc2, w);
        chk("held_wait", 64'(w), 64'd33);
        chk("held_lo", lo, 32'h0000_ABCD);
        chk("held_hi", hi, 32'd2);
        wait_idle();

        // Back-to-back MTHI/MTLO.
        busy_cnt = 0;
        issue(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0, 32'd0, 32'd0, 0, acc1, w);
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo", lo, 32'h0000_ABCD);
        issue(OP_MTLO, 32'h0000_5678, 32'd0, 1'b0, 32'd0, 32'd0, 0, acc2, w);
        chk("mtlo_lo", lo, 32'h0000_5678);
        chk("mt_edges", 64'(acc2 - acc1), 64'd1);
        chk("mt_busy", 64'(busy_cnt), 64'd0);

`ifdef MULDIV_MADD_EN
        run("maddu", OP_MADDU, 32'd2, 32'd3, 32'h0000_1234, 32'h0000_567E, 3, 2);
`else
        busy_cnt = 0;
        issue(OP_MADDU, 32'd2, 32'd3, 1'b0, 32'd0, 32'd0, 0, acc1, w);
        repeat (5) @(negedge clk);
        chk("maddu_wait", 64'(w), 64'd0);
        chk("maddu_hi", hi, 32'h0000_1234);
        chk("maddu_lo", lo, 32'h0000_5678);
        chk("maddu_busy", 64'(busy_cnt), 64'd0);
`endif

        // Reset in the middle of a divide.
        issue(OP_DIV, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 0, acc1, w);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", op_ready, 1'b1);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_done", done, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        run("mult_after_rst", OP_MULT, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 3, 2);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
